// File: rtl/alu_mul_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_mul_seq_pkg                                                  |
// | Purpose  : Shared types and constants for the sequential multiplier:       |
// |            sequencer state encoding and Hack ALU control words.            |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DBL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Control word bit order: {zx, nx, zy, ny, f, no}
  localparam logic [5:0] c_ALU_ZERO     = 6'b101010;
  localparam logic [5:0] c_ALU_X_PLUS_Y = 6'b000010;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_mul_seq_if                                                   |
// | Purpose  : Request/result bundle for the sequential multiplier.            |
// | Ports    : start, a[15:0], b[15:0]          (requester -> multiplier)      |
// |            busy, done, product[15:0], zr, ng (multiplier -> requester)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface alu_mul_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        zr;
  logic        ng;

  modport master (
    output start, a, b,
    input  busy, done, product, zr, ng
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, zr, ng
  );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu                                                              |
// | Purpose  : Hack platform 16-bit ALU (combinational).                       |
// | Ports    : x, y [15:0]            operands                                 |
// |            zx,nx,zy,ny,f,no       control bits                             |
// |            out [15:0]             result                                   |
// |            zr, ng                 out==0, out[15]                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] w_x0;
  logic [15:0] w_x1;
  logic [15:0] w_y0;
  logic [15:0] w_y1;
  logic [15:0] w_f;

  assign w_x0 = zx ? 16'h0000 : x;
  assign w_x1 = nx ? ~w_x0 : w_x0;
  assign w_y0 = zy ? 16'h0000 : y;
  assign w_y1 = ny ? ~w_y0 : w_y0;
  assign w_f  = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
  assign out  = no ? ~w_f : w_f;
  assign zr   = (out == 16'h0000);
  assign ng   = out[15];

endmodule
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_mul_seq                                                      |
// | Purpose  : Shift-and-add 16x16 multiplier (low 16 product bits) built on a |
// |            single Hack ALU, alternating accumulate (ADD) and doubling      |
// |            (DBL) steps, multiplier consumed LSB first.                     |
// | Ports    : clk    rising-edge clock                                        |
// |            rst_n  asynchronous active-low reset                            |
// |            bus    alu_mul_seq_if.slave (start/a/b in,                      |
// |                   busy/done/product/zr/ng out)                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int NUM_BITS   = 16,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_mul_seq_if.slave  bus
);

  localparam logic [4:0] c_LAST_CNT = 5'(NUM_BITS);

  state_e      state_q,  state_d;
  logic [15:0] mcand_q,  mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] acc_q,    acc_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [15:0] result_q, result_d;

  logic [15:0] w_alu_x;
  logic [15:0] w_alu_y;
  logic [5:0]  w_alu_ctrl;
  logic [15:0] w_alu_out;
  logic        w_last;

  // Last DBL step: bit budget exhausted, or (optionally) nothing left to add.
  assign w_last = ((cnt_q + 5'd1) == c_LAST_CNT) ||
                  (EARLY_EXIT && (mplier_q[15:1] == 15'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      acc_q    <= 16'h0000;
      cnt_q    <= 5'd0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    w_alu_x    = 16'h0000;
    w_alu_y    = 16'h0000;
    w_alu_ctrl = c_ALU_ZERO;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = 16'h0000;
          cnt_d    = 5'd0;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        // zy masks the multiplicand when the current multiplier bit is 0,
        // so the step degenerates to acc + 0 without a separate mux.
        w_alu_x    = acc_q;
        w_alu_y    = mcand_q;
        w_alu_ctrl = {1'b0, 1'b0, ~mplier_q[0], 1'b0, 1'b1, 1'b0};
        acc_d      = w_alu_out;
        state_d    = ST_DBL;
      end
      ST_DBL: begin
        // mcand + mcand == mcand << 1; bit 15 falls off the 16-bit adder.
        w_alu_x    = mcand_q;
        w_alu_y    = mcand_q;
        w_alu_ctrl = c_ALU_X_PLUS_Y;
        mcand_d    = w_alu_out;
        mplier_d   = mplier_q >> 1;
        cnt_d      = cnt_q + 5'd1;
        if (w_last) begin
          result_d = acc_q;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_ADD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  alu u_alu (
    .x   (w_alu_x),
    .y   (w_alu_y),
    .zx  (w_alu_ctrl[5]),
    .nx  (w_alu_ctrl[4]),
    .zy  (w_alu_ctrl[3]),
    .ny  (w_alu_ctrl[2]),
    .f   (w_alu_ctrl[1]),
    .no  (w_alu_ctrl[0]),
    .out (w_alu_out),
    .zr  (),
    .ng  ()
  );

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = result_q;
  assign bus.zr      = ~|result_q;
  assign bus.ng      = result_q[15];

endmodule
`default_nettype wire
